// File: rtl/pwm_pkg.sv
// Shared constants and ramp state encoding for the PWM duty path.
package pwm_pkg;

    localparam int PWM_PERIOD_CYCLES = 2000;
    localparam int PWM_MAX_DUTY      = 10;
    localparam int PWM_DW            = 4;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RAMP_UP   = 2'd1,
        RAMP_DOWN = 2'd2
    } ramp_state_t;

endpackage

// File: rtl/pwm_period_timer.sv
// Free-running PWM frame counter with a registered strobe in each frame's first cycle.
module pwm_period_timer
    import pwm_pkg::*;
#(
    parameter int PERIOD = PWM_PERIOD_CYCLES
) (
    input  logic clk_1MHz,
    input  logic rst_n,
    output logic period_start
);

    localparam int CW = (PERIOD > 1) ? $clog2(PERIOD) : 1;

    logic [CW-1:0] count;
    logic          at_end;

    assign at_end = (count == CW'(PERIOD - 1));

    // Strobe is registered from the wrap so it lines up with count==0, but
    // stays low in the very first frame after reset.
    always_ff @(posedge clk_1MHz or negedge rst_n) begin
        if (!rst_n) begin
            count        <= '0;
            period_start <= 1'b0;
        end else begin
            count        <= at_end ? '0 : count + CW'(1);
            period_start <= at_end;
        end
    end

endmodule

// File: rtl/pwm_duty_ramp_ctrl.sv
// Ramps the PWM pulse_width one LSB at a time toward a commanded target,
// updating only on frame boundaries; enable low aborts to zero at once.
module pwm_duty_ramp_ctrl
    import pwm_pkg::*;
#(
    parameter int PERIOD       = PWM_PERIOD_CYCLES,
    parameter int STEP_PERIODS = 10,
    parameter int MAX_DUTY     = PWM_MAX_DUTY,
    parameter int DW           = PWM_DW
) (
    input  logic          clk_1MHz,
    input  logic          rst_n,
    input  logic          enable,
    input  logic          cmd_valid,
    input  logic [DW-1:0] cmd_duty,
    output logic          cmd_ready,
    output logic [DW-1:0] pulse_width,
    output logic          period_start,
    output logic          busy,
    output logic          at_target
);

    localparam int SW = $clog2(STEP_PERIODS + 1);

    ramp_state_t   state, state_next;
    logic [DW-1:0] target, target_next;
    logic [DW-1:0] pw_next;
    logic [SW-1:0] step_cnt, step_next;
    logic [DW-1:0] cmd_clamped;
    logic          step_event;

    pwm_period_timer #(.PERIOD(PERIOD)) u_timer (
        .clk_1MHz     (clk_1MHz),
        .rst_n        (rst_n),
        .period_start (period_start)
    );

    assign cmd_ready   = enable && (state == IDLE);
    assign cmd_clamped = (cmd_duty > DW'(MAX_DUTY)) ? DW'(MAX_DUTY) : cmd_duty;
    assign step_event  = period_start && (step_cnt == SW'(STEP_PERIODS - 1));

    always_comb begin
        state_next  = state;
        target_next = target;
        pw_next     = pulse_width;
        step_next   = step_cnt;
        if (!enable) begin
            // Abort takes priority over any coincident step or command.
            state_next  = IDLE;
            target_next = '0;
            pw_next     = '0;
            step_next   = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        target_next = cmd_clamped;
                        step_next   = '0;
                        if (cmd_clamped > pulse_width)
                            state_next = RAMP_UP;
                        else if (cmd_clamped < pulse_width)
                            state_next = RAMP_DOWN;
                    end
                end
                RAMP_UP: begin
                    if (step_event) begin
                        step_next = '0;
                        pw_next   = pulse_width + DW'(1);
                        if (pw_next == target)
                            state_next = IDLE;
                    end else if (period_start) begin
                        step_next = step_cnt + SW'(1);
                    end
                end
                RAMP_DOWN: begin
                    if (step_event) begin
                        step_next = '0;
                        pw_next   = pulse_width - DW'(1);
                        if (pw_next == target)
                            state_next = IDLE;
                    end else if (period_start) begin
                        step_next = step_cnt + SW'(1);
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_1MHz or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            target      <= '0;
            pulse_width <= '0;
            step_cnt    <= '0;
            busy        <= 1'b0;
            at_target   <= 1'b1;
        end else begin
            state       <= state_next;
            target      <= target_next;
            pulse_width <= pw_next;
            step_cnt    <= step_next;
            busy        <= (state_next != IDLE);
            at_target   <= (state_next == IDLE);
        end
    end

endmodule

// File: tb/tb_pwm_duty_ramp_ctrl.sv
// Directed bench for pwm_duty_ramp_ctrl with a short 20-cycle frame and 2-frame step.
module tb_pwm_duty_ramp_ctrl;

    logic       clk_1MHz = 1'b0;
    logic       rst_n;
    logic       enable;
    logic       cmd_valid;
    logic [3:0] cmd_duty;
    logic       cmd_ready;
    logic [3:0] pulse_width;
    logic       period_start;
    logic       busy;
    logic       at_target;

    int tests_run = 0;
    int tests_failed = 0;
    int cyc = 0;

    pwm_duty_ramp_ctrl #(
        .PERIOD       (20),
        .STEP_PERIODS (2),
        .MAX_DUTY     (10),
        .DW           (4)
    ) dut (
        .clk_1MHz     (clk_1MHz),
        .rst_n        (rst_n),
        .enable       (enable),
        .cmd_valid    (cmd_valid),
        .cmd_duty     (cmd_duty),
        .cmd_ready    (cmd_ready),
        .pulse_width  (pulse_width),
        .period_start (period_start),
        .busy         (busy),
        .at_target    (at_target)
    );

    always #5 clk_1MHz = ~clk_1MHz;
    always @(posedge clk_1MHz) cyc <= cyc + 1;

    task automatic check_val(input string tag, input int got, input int exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end else begin
            $display("ok   %s: %0d", tag, got);
        end
    endtask

    // Returns at the negedge of the next cycle with period_start=1.
    task automatic wait_ps(output int n);
        n = 0;
        do begin
            @(negedge clk_1MHz);
            n++;
        end while (!period_start && n < 200);
        if (!period_start) check_val("ps_wait", int'(period_start), 1);
    endtask

    task automatic send_cmd(input string tag, input int duty);
        check_val({tag, "_ready"}, int'(cmd_ready), 1);
        cmd_duty  = 4'(duty);
        cmd_valid = 1'b1;
        @(negedge clk_1MHz);
        cmd_valid = 1'b0;
    endtask

    // One ramp step: two frame strobes, value held during the step strobe, new value after.
    task automatic step_check(input string tag, input int prev, input int exp, output int at_cyc);
        int n;
        wait_ps(n);
        wait_ps(n);
        check_val({tag, "_hold"}, int'(pulse_width), prev);
        @(negedge clk_1MHz);
        check_val({tag, "_pw"}, int'(pulse_width), exp);
        at_cyc = cyc;
    endtask

    initial begin
        int n, c_prev, c_now, saw_busy, pw_moved;
        rst_n = 1'b0; enable = 1'b1; cmd_valid = 1'b0; cmd_duty = '0;
        repeat (3) @(negedge clk_1MHz);
        rst_n = 1'b1;

        // 1: reset state and frame timing
        check_val("rst_pw", int'(pulse_width), 0);
        check_val("rst_busy", int'(busy), 0);
        check_val("rst_at_target", int'(at_target), 1);
        check_val("rst_ready", int'(cmd_ready), 1);
        check_val("rst_ps_first", int'(period_start), 0);
        wait_ps(n);
        check_val("ps_gap1", n, 20);
        wait_ps(n);
        check_val("ps_gap2", n, 20);

        // 2: ramp 0 -> 5
        send_cmd("up5", 5);
        check_val("up5_busy", int'(busy), 1);
        check_val("up5_ready_low", int'(cmd_ready), 0);
        check_val("up5_at_target", int'(at_target), 0);
        c_prev = 0;
        for (int k = 1; k <= 5; k++) begin
            step_check($sformatf("up5_s%0d", k), k - 1, k, c_now);
            if (k > 1) check_val($sformatf("up5_gap%0d", k), c_now - c_prev, 40);
            c_prev = c_now;
        end
        check_val("up5_done_busy", int'(busy), 0);
        check_val("up5_done_at", int'(at_target), 1);

        // 3: clamp 15 -> 10, then down to 3
        send_cmd("clamp", 15);
        for (int k = 6; k <= 10; k++) step_check($sformatf("clamp_s%0d", k), k - 1, k, c_now);
        check_val("clamp_done_busy", int'(busy), 0);
        repeat (100) @(negedge clk_1MHz);
        check_val("clamp_stays10", int'(pulse_width), 10);
        send_cmd("down3", 3);
        check_val("down3_busy", int'(busy), 1);
        for (int k = 9; k >= 3; k--) step_check($sformatf("down3_s%0d", k), k + 1, k, c_now);
        check_val("down3_done_busy", int'(busy), 0);
        check_val("down3_done_at", int'(at_target), 1);

        // 4: command equal to current value
        send_cmd("same3", 3);
        saw_busy = 0; pw_moved = 0;
        for (int i = 0; i < 100; i++) begin
            if (busy) saw_busy = 1;
            if (pulse_width != 4'd3) pw_moved = 1;
            @(negedge clk_1MHz);
        end
        check_val("same3_busy_never", saw_busy, 0);
        check_val("same3_pw_fixed", pw_moved, 0);
        check_val("same3_ready", int'(cmd_ready), 1);

        // 5: abort coincident with a step event at pw=6
        send_cmd("abort", 10);
        for (int k = 4; k <= 6; k++) step_check($sformatf("abort_s%0d", k), k - 1, k, c_now);
        wait_ps(n);
        wait_ps(n);
        enable = 1'b0;
        check_val("abort_ready_comb", int'(cmd_ready), 0);
        @(negedge clk_1MHz);
        check_val("abort_pw", int'(pulse_width), 0);
        check_val("abort_busy", int'(busy), 0);
        check_val("abort_at", int'(at_target), 1);
        cmd_duty = 4'd8; cmd_valid = 1'b1;
        repeat (5) @(negedge clk_1MHz);
        check_val("abort_refuse_busy", int'(busy), 0);
        check_val("abort_refuse_ready", int'(cmd_ready), 0);
        cmd_valid = 1'b0;
        enable = 1'b1;
        @(negedge clk_1MHz);
        check_val("reen_ready", int'(cmd_ready), 1);
        wait_ps(n);
        wait_ps(n);
        wait_ps(n);
        @(negedge clk_1MHz);
        check_val("reen_pw", int'(pulse_width), 0);
        check_val("reen_busy", int'(busy), 0);

        // 6: asynchronous reset mid-ramp, during a period_start cycle
        send_cmd("rst", 10);
        step_check("rst_s1", 0, 1, c_now);
        wait_ps(n);
        #2 rst_n = 1'b0;
        #1;
        check_val("arst_pw", int'(pulse_width), 0);
        check_val("arst_busy", int'(busy), 0);
        check_val("arst_ps", int'(period_start), 0);
        check_val("arst_at", int'(at_target), 1);
        @(negedge clk_1MHz);
        rst_n = 1'b1;
        wait_ps(n);
        check_val("arst_ps_gap", n, 20);
        check_val("arst_pw_after", int'(pulse_width), 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
